// File: rtl/prog_inst_memory.sv
// -----------------------------------------------------------------------------
// prog_inst_memory
//
// Runtime-loadable, word-addressed instruction RAM for the single-cycle RV32I
// core. Words arrive over a valid/ready load port while the block is in LOAD.
// A one-cycle SETTLE bubble follows the final word. Then the fetch stage reads
// the RAM in RUN with one cycle of registered latency.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-low reset
//   pc_in         byte-address PC
//   fetch_en      1 = fetch this cycle, 0 = stall (outputs hold)
//   inst_out      fetched instruction, or NOP_INST when no valid fetch
//   inst_valid    inst_out holds a real fetch result
//   misalign_err  last fetch had pc_in[1:0] != 0
//   range_err     last fetch had pc_in[31:2] >= DEPTH
//   ld_start      enter or restart LOAD; clears ld_count and ld_err
//   ld_valid      load word offered
//   ld_ready      load word accepted when ld_valid & ld_ready
//   ld_addr       word index to write
//   ld_data       word to write
//   ld_last       marks the final word of a load
//   ld_count      words accepted since last ld_start/reset, saturates at DEPTH
//   ld_err        sticky: a load word had ld_addr >= DEPTH
//   busy          block is not in RUN
// -----------------------------------------------------------------------------
module prog_inst_memory #(
   parameter int               XLEN     = 32,
   parameter int               DEPTH    = 1024,
   parameter int               AW       = $clog2(DEPTH),
   parameter logic [XLEN-1:0]  NOP_INST = XLEN'(32'h00000013)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      pc_in,
   input  logic             fetch_en,
   output logic [XLEN-1:0]  inst_out,
   output logic             inst_valid,
   output logic             misalign_err,
   output logic             range_err,
   input  logic             ld_start,
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic [AW-1:0]    ld_addr,
   input  logic [XLEN-1:0]  ld_data,
   input  logic             ld_last,
   output logic [AW:0]      ld_count,
   output logic             ld_err,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

   localparam logic [AW:0] DEPTH_CNT   = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE     = (AW+1)'(1);
   localparam logic [29:0] DEPTH_WORDS = 30'(DEPTH);

   logic [XLEN-1:0] mem_q [DEPTH];
   logic [XLEN-1:0] rd_data_q;

   state_t          state_q, state_d;
   logic [AW:0]     ld_count_q, ld_count_d;
   logic [AW:0]     count_base;
   logic            ld_err_q, ld_err_d;
   logic            ld_ready_q, busy_q;
   logic            sel_mem_q, sel_mem_d;
   logic            inst_valid_q, inst_valid_d;
   logic            misalign_q, misalign_d;
   logic            range_q, range_d;

   logic            accept, addr_ok, wr_en, rd_en;
   logic            pc_misalign, pc_range, fetch_go;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      // ld_ready_q is high exactly when the state is LOAD, so acceptance can
      // be decoded from the state without reading the output register.
      accept  = (state_q == ST_LOAD) && ld_valid;
      addr_ok = ({1'b0, ld_addr} < DEPTH_CNT);
      // A beat sampled while reset is asserted is discarded with the load.
      wr_en   = accept && addr_ok && rst;

      // ld_start clears first, so a coincident beat leaves the count at 1.
      count_base = ld_start ? '0 : ld_count_q;
      ld_count_d = count_base;
      if (accept && (count_base != DEPTH_CNT)) begin
         ld_count_d = count_base + CNT_ONE;
      end
      ld_err_d = (ld_err_q && !ld_start) || (accept && !addr_ok);

      state_d = state_q;
      if (ld_start) begin
         state_d = ST_LOAD;
      end else begin
         case (state_q)
            ST_LOAD:   if (accept && ld_last) state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_RUN;
            ST_RUN:    state_d = ST_RUN;
            default:   state_d = ST_LOAD;
         endcase
      end

      pc_misalign = (pc_in[1:0] != 2'b00);
      pc_range    = (pc_in[31:2] >= DEPTH_WORDS);
      // A fetch in the same cycle as ld_start is discarded.
      fetch_go    = (state_q == ST_RUN) && !ld_start && fetch_en;
      rd_en       = fetch_go && !pc_misalign && !pc_range;

      sel_mem_d    = sel_mem_q;
      inst_valid_d = inst_valid_q;
      misalign_d   = misalign_q;
      range_d      = range_q;
      if ((state_q != ST_RUN) || ld_start) begin
         sel_mem_d    = 1'b0;
         inst_valid_d = 1'b0;
         misalign_d   = 1'b0;
         range_d      = 1'b0;
      end else if (fetch_en) begin
         // Misalignment outranks range: a misaligned out-of-range PC
         // reports misalign_err only.
         sel_mem_d    = !pc_misalign && !pc_range;
         inst_valid_d = 1'b1;
         misalign_d   = pc_misalign;
         range_d      = !pc_misalign && pc_range;
      end
   end

   // ---------------------------------------------------------------------
   // Control registers (FSM and registered outputs)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_LOAD;
         ld_count_q   <= '0;
         ld_err_q     <= 1'b0;
         ld_ready_q   <= 1'b1;
         busy_q       <= 1'b1;
         sel_mem_q    <= 1'b0;
         inst_valid_q <= 1'b0;
         misalign_q   <= 1'b0;
         range_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         ld_count_q   <= ld_count_d;
         ld_err_q     <= ld_err_d;
         ld_ready_q   <= (state_d == ST_LOAD);
         busy_q       <= (state_d != ST_RUN);
         sel_mem_q    <= sel_mem_d;
         inst_valid_q <= inst_valid_d;
         misalign_q   <= misalign_d;
         range_q      <= range_d;
      end
   end

   // ---------------------------------------------------------------------
   // Storage: contents are never reset. Writes happen only in LOAD and reads
   // only in RUN, so the two ports never touch the same cycle. The read
   // register updates only on an in-range fetch and holds across stalls.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[ld_addr] <= ld_data;
      end
      if (rd_en) begin
         rd_data_q <= mem_q[pc_in[AW+1:2]];
      end
   end

   assign inst_out     = sel_mem_q ? rd_data_q : NOP_INST;
   assign inst_valid   = inst_valid_q;
   assign misalign_err = misalign_q;
   assign range_err    = range_q;
   assign ld_ready     = ld_ready_q;
   assign ld_count     = ld_count_q;
   assign ld_err       = ld_err_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_prog_inst_memory.sv
module tb_prog_inst_memory;

   localparam int          XLEN  = 32;
   localparam int          DEPTH = 12;
   localparam int          AW    = $clog2(DEPTH);
   localparam logic [31:0] NOP   = 32'h00000013;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [31:0]      pc_in = '0;
   logic             fetch_en = 1'b0;
   logic [XLEN-1:0]  inst_out;
   logic             inst_valid, misalign_err, range_err;
   logic             ld_start = 1'b0;
   logic             ld_valid = 1'b0;
   logic             ld_ready;
   logic [AW-1:0]    ld_addr = '0;
   logic [XLEN-1:0]  ld_data = '0;
   logic             ld_last = 1'b0;
   logic [AW:0]      ld_count;
   logic             ld_err, busy;

   prog_inst_memory #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .fetch_en(fetch_en),
      .inst_out(inst_out), .inst_valid(inst_valid),
      .misalign_err(misalign_err), .range_err(range_err),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
      .ld_count(ld_count), .ld_err(ld_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: memory image, load counters, expected fetch outputs.
   logic [31:0] m_mem   [DEPTH];
   bit          m_known [DEPTH];
   int          m_count = 0;
   bit          m_err   = 0;
   logic [31:0] e_inst  = NOP;
   bit          e_valid = 0, e_mis = 0, e_rng = 0, e_known = 1;

   typedef struct {
      logic [31:0] pc;
      bit          en;
      logic [31:0] inst;
      bit          valid;
      bit          mis;
      bit          rng;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ld_start = 0; ld_valid = 0; ld_last = 0; fetch_en = 0;
   endtask

   task automatic reset_expect();
      e_inst = NOP; e_valid = 0; e_mis = 0; e_rng = 0; e_known = 1;
   endtask

   // One accepted beat in LOAD, optionally with ld_start in the same cycle.
   task automatic beat(input logic [AW-1:0] a, input logic [31:0] d, input bit last, input bit start);
      ld_addr = a; ld_data = d; ld_valid = 1; ld_last = last; ld_start = start;
      tick();
      if (start) begin m_count = 0; m_err = 0; end
      if (m_count < DEPTH) m_count++;
      if (int'(a) < DEPTH) begin m_mem[a] = d; m_known[a] = 1; end
      else m_err = 1;
      idle();
      chk("beat ld_count", ld_count, m_count);
      chk("beat ld_err", ld_err, m_err);
   endtask

   // Called right after the edge that accepted ld_last.
   task automatic settle_to_run();
      chk("settle busy", busy, 1);
      chk("settle ld_ready", ld_ready, 0);
      chk("settle inst_valid", inst_valid, 0);
      idle();
      tick();
      chk("run busy", busy, 0);
      chk("run ld_ready", ld_ready, 0);
      chk("run inst_valid", inst_valid, 0);
      chk("run inst_out", inst_out, NOP);
      reset_expect();
   endtask

   // ld_start from RUN with a competing fetch request that must be dropped.
   task automatic do_start();
      pc_in = 32'h0; fetch_en = 1; ld_start = 1;
      tick();
      idle();
      m_count = 0; m_err = 0;
      reset_expect();
      chk("start busy", busy, 1);
      chk("start ld_ready", ld_ready, 1);
      chk("start inst_valid", inst_valid, 0);
      chk("start inst_out", inst_out, NOP);
      chk("start ld_count", ld_count, 0);
      chk("start ld_err", ld_err, 0);
   endtask

   // Fetch in RUN checked against the behavioural rules.
   task automatic fetch(input logic [31:0] pc, input bit en);
      int idx;
      pc_in = pc; fetch_en = en;
      tick();
      if (en) begin
         e_valid = 1; e_mis = 0; e_rng = 0; e_known = 1; e_inst = NOP;
         if (pc % 4 != 0) e_mis = 1;
         else if (pc / 4 >= DEPTH) e_rng = 1;
         else begin
            idx = int'(pc / 4);
            e_inst = m_mem[idx];
            e_known = m_known[idx];
         end
      end
      chk($sformatf("fetch %h valid", pc), inst_valid, e_valid);
      chk($sformatf("fetch %h misalign", pc), misalign_err, e_mis);
      chk($sformatf("fetch %h range", pc), range_err, e_rng);
      if (e_known) chk($sformatf("fetch %h inst", pc), inst_out, e_inst);
   endtask

   task automatic rand_load();
      int n, sent;
      bit v, fin, st;
      logic [AW-1:0] a;
      logic [31:0] d;
      n = $urandom_range(1, 16);
      sent = 0;
      do_start();
      while (sent < n) begin
         v   = ($urandom_range(0, 3) != 0);
         fin = v && (sent == n - 1);
         st  = !fin && ($urandom_range(0, 9) == 0);
         a   = AW'($urandom_range(0, 15));
         d   = $urandom;
         ld_addr = a; ld_data = d; ld_valid = v; ld_last = fin; ld_start = st;
         tick();
         if (st) begin m_count = 0; m_err = 0; end
         if (v) begin
            if (m_count < DEPTH) m_count++;
            if (int'(a) < DEPTH) begin m_mem[a] = d; m_known[a] = 1; end
            else m_err = 1;
            sent++;
         end
         chk("rand ld_count", ld_count, m_count);
         chk("rand ld_err", ld_err, m_err);
         chk("rand busy", busy, 1);
         chk("rand ld_ready", ld_ready, !fin);
      end
      settle_to_run();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      logic [31:0] pc;
      for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_known[i] = 0; end

      // Reset held for two edges.
      idle();
      rst = 0;
      tick(); tick();
      chk("reset busy", busy, 1);
      chk("reset ld_ready", ld_ready, 1);
      chk("reset inst_valid", inst_valid, 0);
      chk("reset inst_out", inst_out, NOP);
      chk("reset ld_count", ld_count, 0);
      chk("reset ld_err", ld_err, 0);
      chk("reset misalign", misalign_err, 0);
      chk("reset range", range_err, 0);
      rst = 1;
      tick();
      chk("post-reset busy", busy, 1);
      chk("post-reset ld_ready", ld_ready, 1);

      // Initial load of three words.
      beat(0, 32'h002081B3, 0, 0);
      beat(1, 32'h403202B3, 0, 0);
      beat(2, 32'h00308383, 1, 0);
      chk("load ld_count", ld_count, 3);
      // A beat offered during SETTLE is ignored.
      ld_valid = 1; ld_addr = 5; ld_data = 32'hFFFFFFFF;
      chk("settle busy", busy, 1);
      chk("settle ld_ready", ld_ready, 0);
      tick();
      idle();
      chk("settle-beat ld_count", ld_count, 3);
      chk("run busy", busy, 0);
      chk("run inst_valid", inst_valid, 0);

      // Table-driven fetch and stall vectors.
      tbl.push_back('{32'h00000000, 1, 32'h002081B3, 1, 0, 0});
      tbl.push_back('{32'h00000004, 1, 32'h403202B3, 1, 0, 0});
      tbl.push_back('{32'h00000008, 1, 32'h00308383, 1, 0, 0});
      tbl.push_back('{32'h00000020, 0, 32'h00308383, 1, 0, 0});
      tbl.push_back('{32'h00000006, 0, 32'h00308383, 1, 0, 0});
      tbl.push_back('{32'h00000000, 0, 32'h00308383, 1, 0, 0});
      tbl.push_back('{32'h00000004, 1, 32'h403202B3, 1, 0, 0});
      tbl.push_back('{32'h00000006, 1, NOP,          1, 1, 0});
      tbl.push_back('{32'h00000030, 1, NOP,          1, 0, 1});
      tbl.push_back('{32'h00000000, 0, NOP,          1, 0, 1});
      tbl.push_back('{32'h00000033, 1, NOP,          1, 1, 0});
      tbl.push_back('{32'hFFFFFFFC, 1, NOP,          1, 0, 1});
      tbl.push_back('{32'h00000008, 1, 32'h00308383, 1, 0, 0});
      foreach (tbl[i]) begin
         pc_in = tbl[i].pc; fetch_en = tbl[i].en;
         tick();
         chk($sformatf("vec%0d inst", i), inst_out, tbl[i].inst);
         chk($sformatf("vec%0d valid", i), inst_valid, tbl[i].valid);
         chk($sformatf("vec%0d misalign", i), misalign_err, tbl[i].mis);
         chk($sformatf("vec%0d range", i), range_err, tbl[i].rng);
      end
      idle();

      // Beat offered in RUN is ignored.
      ld_valid = 1; ld_addr = 0; ld_data = 32'hFFFFFFFF;
      tick();
      idle();
      chk("run-beat ld_count", ld_count, 3);
      chk("run-beat busy", busy, 0);

      // Reload from RUN: out-of-range beat, start+beat, start+last, final word.
      do_start();
      beat(AW'(DEPTH), 32'hBAD0BAD0, 0, 0);
      chk("oob ld_err", ld_err, 1);
      beat(11, 32'h00A00093, 1, 1);
      chk("start+last ld_count", ld_count, 1);
      chk("start+last busy", busy, 1);
      chk("start+last ld_ready", ld_ready, 1);
      beat(1, 32'h00110293, 1, 0);
      settle_to_run();
      fetch(32'h4, 1);
      chk("reload word1", inst_out, 32'h00110293);
      fetch(32'h0, 1);
      chk("reload word0 kept", inst_out, 32'h002081B3);
      fetch(32'h8, 1);
      fetch(32'h2C, 1);
      chk("last in-range word", inst_out, 32'h00A00093);
      fetch(32'h30, 1);
      fetch(32'h31, 1);

      // Reset in the middle of a four-word load.
      do_start();
      beat(2, 32'h00500113, 0, 0);
      beat(3, 32'h00600193, 0, 0);
      rst = 0; ld_valid = 1; ld_addr = 4; ld_data = 32'h11111111;
      tick();
      rst = 1;
      idle();
      m_count = 0; m_err = 0;
      chk("midrst ld_count", ld_count, 0);
      chk("midrst busy", busy, 1);
      chk("midrst ld_ready", ld_ready, 1);
      chk("midrst inst_valid", inst_valid, 0);
      beat(4, 32'h00700213, 0, 0);
      beat(5, 32'h00800293, 1, 0);
      settle_to_run();
      fetch(32'h8, 1);
      chk("midrst word2 kept", inst_out, 32'h00500113);
      fetch(32'hC, 1);
      fetch(32'h10, 1);
      fetch(32'h14, 1);
      fetch(32'h0, 1);

      // Randomised reload/fetch sessions against the model.
      for (int s = 0; s < 10; s++) begin
         rand_load();
         for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
               0, 1, 2: pc = 32'($urandom_range(0, DEPTH - 1)) << 2;
               3:       pc = (32'($urandom_range(0, DEPTH + 3)) << 2) | 32'($urandom_range(1, 3));
               4:       pc = 32'($urandom_range(DEPTH, DEPTH + 100)) << 2;
               default: pc = $urandom;
            endcase
            fetch(pc, $urandom_range(0, 3) != 0);
         end
         idle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
